// File: rtl/bdy_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bdy_seq_ctrl
//
// Job sequencer in front of the MDL_BDY butterfly/PWM datapath. One command
// at a time is accepted and run through four phases:
//   LOAD  - PRM_COEFFS beats pass from the host input stream into MDL_BDY
//   KICK  - one-cycle oCTL_MODE pulse carrying the op code (skipped for op 0)
//   WAIT  - idle until MDL_BDY offers its first result, bounded by PRM_TMO
//   DRAIN - PRM_COEFFS result beats pass back to the host, TLAST generated here
// followed by a one-cycle DONE state that pulses oDONE.
//
// Both stream paths are zero-latency combinational pass-throughs. Only the
// valid/ready pair of the active phase is opened, so backpressure propagates
// straight through and nothing is buffered.
//
// Ports
//   iSYS_CLK, iSYS_RST        clock (rising edge), async active-low reset
//   iCMD_VALID/oCMD_READY     command handshake; oCMD_READY high only in IDLE
//   iCMD_OP/iCMD_Q/iCMD_BUT   op code (0 = no kick), modulus select, butterfly
//                             config; all latched on accept
//   iS_AXIS_*  / oS_AXIS_TREADY   host input stream (active in LOAD)
//   oB_AXIS_*  / iB_AXIS_TREADY   MDL_BDY slave port (active in LOAD)
//   iB_M_AXIS_* / oB_M_AXIS_TREADY  MDL_BDY master port (active in DRAIN);
//                             its TLAST is not used
//   oM_AXIS_*  / iM_AXIS_TREADY   host output stream (active in DRAIN)
//   oCTL_MODE/oCTL_Q/oCTL_BUT MDL_BDY control inputs
//   oBUSY                     state is not IDLE
//   oDONE                     one-cycle pulse at job end
//   oERR                      sticky error, cleared on next command accept
//   oSTATE                    current state, for debug
// ---------------------------------------------------------------------------
module bdy_seq_ctrl #(
    parameter int PRM_DAXI   = 64,
    parameter int PRM_COEFFS = 4096,
    parameter int PRM_CNTW   = 13,
    parameter int PRM_TMO    = 65535
) (
    input  logic                    iSYS_CLK,
    input  logic                    iSYS_RST,

    input  logic                    iCMD_VALID,
    output logic                    oCMD_READY,
    input  logic [2:0]              iCMD_OP,
    input  logic [1:0]              iCMD_Q,
    input  logic [1:0]              iCMD_BUT,

    input  logic                    iS_AXIS_TVALID,
    input  logic [PRM_DAXI-1:0]     iS_AXIS_TDATA,
    input  logic [PRM_DAXI/8-1:0]   iS_AXIS_TKEEP,
    input  logic                    iS_AXIS_TLAST,
    output logic                    oS_AXIS_TREADY,

    output logic                    oB_AXIS_TVALID,
    output logic [PRM_DAXI-1:0]     oB_AXIS_TDATA,
    output logic [PRM_DAXI/8-1:0]   oB_AXIS_TKEEP,
    output logic                    oB_AXIS_TLAST,
    input  logic                    iB_AXIS_TREADY,

    input  logic                    iB_M_AXIS_TVALID,
    input  logic [PRM_DAXI-1:0]     iB_M_AXIS_TDATA,
    input  logic [PRM_DAXI/8-1:0]   iB_M_AXIS_TKEEP,
    output logic                    oB_M_AXIS_TREADY,

    output logic                    oM_AXIS_TVALID,
    output logic [PRM_DAXI-1:0]     oM_AXIS_TDATA,
    output logic [PRM_DAXI/8-1:0]   oM_AXIS_TKEEP,
    output logic                    oM_AXIS_TLAST,
    input  logic                    iM_AXIS_TREADY,

    output logic [2:0]              oCTL_MODE,
    output logic [1:0]              oCTL_Q,
    output logic [1:0]              oCTL_BUT,
    output logic                    oBUSY,
    output logic                    oDONE,
    output logic                    oERR,
    output logic [2:0]              oSTATE
);

    localparam int TMOW = $clog2(PRM_TMO + 1);
    localparam logic [PRM_CNTW-1:0] LAST_BEAT = PRM_CNTW'(PRM_COEFFS - 1);
    localparam logic [TMOW-1:0]     TMO_LIMIT = TMOW'(PRM_TMO);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        KICK  = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t               state;
    logic [PRM_CNTW-1:0]  beatCnt;
    logic [TMOW-1:0]      tmoCnt;
    logic [2:0]           cmdOp;
    logic [2:0]           ctlMode;
    logic [1:0]           ctlQ;
    logic [1:0]           ctlBut;
    logic                 doneReg;
    logic                 errReg;

    logic                 loadPhase;
    logic                 drainPhase;
    logic                 loadBeat;
    logic                 drainBeat;
    logic                 lastBeat;

    assign loadPhase  = (state == LOAD);
    assign drainPhase = (state == DRAIN);
    assign lastBeat   = (beatCnt == LAST_BEAT);

    // Host -> MDL_BDY. Only the handshake pair is gated; payload lines are
    // wired straight across because they mean nothing without a valid.
    assign oB_AXIS_TVALID = loadPhase & iS_AXIS_TVALID;
    assign oS_AXIS_TREADY = loadPhase & iB_AXIS_TREADY;
    assign oB_AXIS_TDATA  = iS_AXIS_TDATA;
    assign oB_AXIS_TKEEP  = iS_AXIS_TKEEP;
    assign oB_AXIS_TLAST  = iS_AXIS_TLAST;
    assign loadBeat       = oB_AXIS_TVALID & iB_AXIS_TREADY;

    // MDL_BDY -> host. TLAST is regenerated from the beat count; the one
    // coming out of MDL_BDY is not trusted.
    assign oM_AXIS_TVALID   = drainPhase & iB_M_AXIS_TVALID;
    assign oB_M_AXIS_TREADY = drainPhase & iM_AXIS_TREADY;
    assign oM_AXIS_TDATA    = iB_M_AXIS_TDATA;
    assign oM_AXIS_TKEEP    = iB_M_AXIS_TKEEP;
    assign oM_AXIS_TLAST    = drainPhase & lastBeat;
    assign drainBeat        = oM_AXIS_TVALID & iM_AXIS_TREADY;

    assign oCMD_READY = (state == IDLE);
    assign oBUSY      = (state != IDLE);
    assign oSTATE     = state;
    assign oCTL_MODE  = ctlMode;
    assign oCTL_Q     = ctlQ;
    assign oCTL_BUT   = ctlBut;
    assign oDONE      = doneReg;
    assign oERR       = errReg;

    // NOTE: state registers take non-blocking assignments only, so every
    // branch below reads the pre-edge values no matter the statement order.
    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            state   <= IDLE;
            beatCnt <= '0;
            tmoCnt  <= '0;
            cmdOp   <= '0;
            ctlMode <= '0;
            ctlQ    <= '0;
            ctlBut  <= '0;
            doneReg <= 1'b0;
            errReg  <= 1'b0;
        end else begin
            // Pulse outputs default low; only the transitions into KICK
            // and DONE raise them, each for exactly one cycle.
            ctlMode <= '0;
            doneReg <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (iCMD_VALID) begin
                        cmdOp   <= iCMD_OP;
                        ctlQ    <= iCMD_Q;
                        ctlBut  <= iCMD_BUT;
                        beatCnt <= '0;
                        errReg  <= 1'b0;
                        state   <= LOAD;
                    end
                end

                LOAD: begin
                    if (loadBeat) begin
                        if (lastBeat) begin
                            // Full load: a missing TLAST is flagged but the
                            // job goes on, since the beat count is what
                            // MDL_BDY actually depends on.
                            if (!iS_AXIS_TLAST) begin
                                errReg <= 1'b1;
                            end
                            beatCnt <= '0;
                            tmoCnt  <= '0;
                            if (cmdOp == 3'd0) begin
                                state <= WAIT;
                            end else begin
                                ctlMode <= cmdOp;
                                state   <= KICK;
                            end
                        end else if (iS_AXIS_TLAST) begin
                            // Short frame: the beat has already gone to
                            // MDL_BDY; abandon the job without kicking.
                            errReg  <= 1'b1;
                            doneReg <= 1'b1;
                            state   <= DONE;
                        end else begin
                            beatCnt <= beatCnt + 1'b1;
                        end
                    end
                end

                KICK: begin
                    beatCnt <= '0;
                    tmoCnt  <= '0;
                    state   <= WAIT;
                end

                WAIT: begin
                    beatCnt <= '0;
                    // The first result only opens DRAIN; it is consumed
                    // there, never here.
                    if (iB_M_AXIS_TVALID) begin
                        state <= DRAIN;
                    end else if (tmoCnt == TMO_LIMIT) begin
                        errReg  <= 1'b1;
                        doneReg <= 1'b1;
                        state   <= DONE;
                    end else begin
                        tmoCnt <= tmoCnt + 1'b1;
                    end
                end

                DRAIN: begin
                    if (drainBeat) begin
                        if (lastBeat) begin
                            doneReg <= 1'b1;
                            state   <= DONE;
                        end else begin
                            beatCnt <= beatCnt + 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
